// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller and for other users
// of the PC register: state encoding, reset PC default, skid entry width.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned SKID_W           = 64;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding {pc, inst} for a fetch that returned while
// the decode slot was still occupied.
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [SKID_W-1:0] data_i,
    output logic              valid_o,
    output logic [SKID_W-1:0] data_o
);

    logic              valid_q;
    logic [SKID_W-1:0] data_q;

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives a single-request instruction memory,
// delivers one instruction per ack to decode, handles stalls and redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_tgt_q, redir_tgt_d;

    logic              skid_load;
    logic              skid_unload;
    logic              skid_clear;
    logic              skid_valid;
    logic [SKID_W-1:0] skid_data;

    fetch_skid_buf u_skid (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   ({pc_q, imem_rdata}),
        .valid_o  (skid_valid),
        .data_o   (skid_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_inst_q    <= '0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_inst_q    <= if_inst_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (br_valid) begin
                    if_valid_d = 1'b0;
                    skid_clear = 1'b1;
                    if (imem_ack) begin
                        pc_d         = word_align(br_target);
                        redir_pend_d = 1'b0;
                    end else begin
                        redir_pend_d = 1'b1;
                        redir_tgt_d  = word_align(br_target);
                    end
                end else begin
                    if (if_valid_q && !stall) begin
                        if_valid_d = 1'b0;
                    end
                    if (imem_ack) begin
                        // Request in flight at redirect time returns wrong-path data.
                        if (redir_pend_q) begin
                            pc_d         = redir_tgt_q;
                            redir_pend_d = 1'b0;
                        end else if (!if_valid_q || !stall) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_inst_d  = imem_rdata;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            skid_load = 1'b1;
                            pc_d      = pc_q + 32'd4;
                            state_d   = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (br_valid) begin
                    if_valid_d = 1'b0;
                    skid_clear = 1'b1;
                    pc_d       = word_align(br_target);
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    if_valid_d  = skid_valid;
                    if_pc_d     = skid_data[63:32];
                    if_inst_d   = skid_data[31:0];
                    skid_unload = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule
